seg7_scan_capture: RTL and testbench

Sampling decoder for a time-multiplexed 7-segment display bus: the reverse of the digit-to-segment encoder. It watches the segment lines and one-hot digit strobes driven toward a display and waits for each strobe/pattern pair to be stable. It then decodes the pattern back to a 4-bit value and stores it per digit position. Used in display loop-back self-test and in the bench path that checks display drivers at system level.

---
 rtl/seg7_scan_capture_if.sv | 38 +++
 rtl/seg7_scan_capture.sv | 194 +++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_capture_if
// Description : Bundle of the multiplexed 7-segment display bus and the
//               capture results produced by seg7_scan_capture.
//               seg/dig  : segment pattern (seg[6]=a .. seg[0]=g) and
//                          one-hot digit strobe driven toward the display
//               num      : captured values, digit i in num[4i+3:4i]
//               digit_valid, cap_valid, cap_idx, cap_num, err, frame_done :
//                          capture status and pulses
//               master   : side that drives the display bus
//               slave    : the capture block
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_capture_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig;
    logic [4*NUM_DIGITS-1:0] num;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    cap_valid;
    logic [2:0]              cap_idx;
    logic [3:0]              cap_num;
    logic                    err;
    logic                    frame_done;

    modport master (
        output seg, dig,
        input  num, digit_valid, cap_valid, cap_idx, cap_num, err, frame_done
    );

    modport slave (
        input  seg, dig,
        output num, digit_valid, cap_valid, cap_idx, cap_num, err, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_capture
// Description : Watches a time-multiplexed 7-segment bus, waits for each
//               strobe/pattern pair to be stable for STABLE_CYCLES samples,
//               decodes the pattern back to 0..9 and stores it per digit.
//               Ports : clk, rst (asynchronous, active-high),
//                       bus (seg7_scan_capture_if.slave)
//               Params: NUM_DIGITS (1-8), STABLE_CYCLES (2-255)
//               Macro : SEG7_CAP_SYNC_EN - adds a two-flop synchronizer in
//                       front of the sample register (+2 cycles latency)
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input wire clk,
    input wire rst,
    seg7_scan_capture_if.slave bus
);
    localparam int         c_sw      = NUM_DIGITS + 7;
    localparam logic [7:0] c_cap_cnt = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] c_sat_cnt = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [c_sw-1:0]         w_pins;
    logic [c_sw-1:0]         r_smp;
    logic [7:0]              r_cnt;
    logic                    w_chg;
    logic [NUM_DIGITS-1:0]   w_new_dig;
    logic                    w_new_onehot;
    logic                    w_cap;
    logic [4:0]              w_dec;
    logic [NUM_DIGITS-1:0]   w_smp_dig;
    logic [2:0]              w_idx;
    logic                    w_full;
    logic [4*NUM_DIGITS-1:0] r_num, w_num_nxt;
    logic [NUM_DIGITS-1:0]   r_dv, w_dv_nxt;
    logic [NUM_DIGITS-1:0]   r_mask, w_mask_nxt;
    logic                    r_cap_valid, r_err, r_frame_done;
    logic [2:0]              r_cap_idx;
    logic [3:0]              r_cap_num;

`ifdef SEG7_CAP_SYNC_EN
    logic [c_sw-1:0] r_sync1, r_sync2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {bus.dig, bus.seg};
            r_sync2 <= r_sync1;
        end
    end
    assign w_pins = r_sync2;
`else
    assign w_pins = {bus.dig, bus.seg};
`endif

    // Comparing the incoming value with the current sample tells us, at the
    // edge itself, whether the sample register is about to change.
    assign w_chg        = (w_pins != r_smp);
    assign w_new_dig    = w_pins[c_sw-1:7];
    assign w_new_onehot = (w_new_dig != '0) && ((w_new_dig & (w_new_dig - 1'b1)) == '0);
    assign w_smp_dig    = r_smp[c_sw-1:7];
    assign w_full       = &r_mask;

    // {legal, value}; exact pattern match only.
    function automatic logic [4:0] f_decode(input logic [6:0] s);
        case (s)
            7'b1111110: f_decode = {1'b1, 4'd0};
            7'b0110000: f_decode = {1'b1, 4'd1};
            7'b1101101: f_decode = {1'b1, 4'd2};
            7'b1111001: f_decode = {1'b1, 4'd3};
            7'b0110011: f_decode = {1'b1, 4'd4};
            7'b1011011: f_decode = {1'b1, 4'd5};
            7'b1011111: f_decode = {1'b1, 4'd6};
            7'b1110000: f_decode = {1'b1, 4'd7};
            7'b1111111: f_decode = {1'b1, 4'd8};
            7'b1110011: f_decode = {1'b1, 4'd9};
            default:    f_decode = 5'd0;
        endcase
    endfunction

    assign w_dec = f_decode(r_smp[6:0]);

    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_smp_dig[i]) w_idx = 3'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_chg && w_new_onehot) w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_chg) begin
                    w_state_nxt = w_new_onehot ? S_SETTLE : S_IDLE;
                end else if (r_cnt == c_cap_cnt) begin
                    // This edge brings the count to STABLE_CYCLES.
                    w_cap       = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_chg) w_state_nxt = w_new_onehot ? S_SETTLE : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_smp <= '0;
            r_cnt <= 8'd0;
        end else begin
            r_smp <= w_pins;
            if (w_chg || (r_state == S_IDLE)) r_cnt <= 8'd0;
            else if (r_cnt != c_sat_cnt)      r_cnt <= r_cnt + 8'd1;
        end
    end

    // The frame clear is applied first so a capture in the same cycle
    // lands in the new frame.
    always_comb begin
        w_num_nxt  = r_num;
        w_dv_nxt   = r_dv;
        w_mask_nxt = w_full ? '0 : r_mask;
        if (w_cap) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_smp_dig[i]) begin
                    if (w_dec[4]) begin
                        w_num_nxt[i*4 +: 4] = w_dec[3:0];
                        w_dv_nxt[i]         = 1'b1;
                        w_mask_nxt[i]       = 1'b1;
                    end else begin
                        w_dv_nxt[i]         = 1'b0;
                        w_mask_nxt[i]       = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num        <= '0;
            r_dv         <= '0;
            r_mask       <= '0;
            r_cap_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;
            r_cap_idx    <= 3'd0;
            r_cap_num    <= 4'd0;
        end else begin
            r_num        <= w_num_nxt;
            r_dv         <= w_dv_nxt;
            r_mask       <= w_mask_nxt;
            r_cap_valid  <= w_cap && w_dec[4];
            r_err        <= w_cap && !w_dec[4];
            r_frame_done <= w_full;
            if (w_cap) begin
                r_cap_idx <= w_idx;
                if (w_dec[4]) r_cap_num <= w_dec[3:0];
            end
        end
    end

    assign bus.num         = r_num;
    assign bus.digit_valid = r_dv;
    assign bus.cap_valid   = r_cap_valid;
    assign bus.cap_idx     = r_cap_idx;
    assign bus.cap_num     = r_cap_num;
    assign bus.err         = r_err;
    assign bus.frame_done  = r_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_capture
// Description : Self-checking bench for seg7_scan_capture (NUM_DIGITS=4,
//               STABLE_CYCLES=4). Stimulus queues expected pulses with the
//               cycle they must appear in; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_capture;
    localparam int ND = 4;
    localparam int SC = 4;
`ifdef SEG7_CAP_SYNC_EN
    localparam int LAT = SC + 3;
`else
    localparam int LAT = SC + 1;
`endif
    localparam int K_CAP = 0, K_ERR = 1, K_FRM = 2;

    typedef struct {
        int kind;
        int idx;
        int num;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_events = 0;
    ev_t  q[$];

    seg7_scan_capture_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int idx, input int num, input int at);
        ev_t e;
        e.kind = kind; e.idx = idx; e.num = num; e.cyc = at;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] d, input logic [6:0] s);
        bus.dig = d;
        bus.seg = s;
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cap_valid && bus.err) begin
                checks++; failures++;
                $display("FAIL cap_err_excl actual=both_high required=exclusive cyc=%0d", cyc);
            end
            if (bus.cap_valid || bus.err) begin
                n_events++;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_cap actual=valid%0d_err%0d idx=%0d num=%0d cyc=%0d required=none",
                             bus.cap_valid, bus.err, bus.cap_idx, bus.cap_num, cyc);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    if (e.kind != (bus.cap_valid ? K_CAP : K_ERR) || e.idx != int'(bus.cap_idx) ||
                        e.num != int'(bus.cap_num) || e.cyc != cyc) begin
                        failures++;
                        $display("FAIL capture actual=kind%0d idx%0d num%0d cyc%0d required=kind%0d idx%0d num%0d cyc%0d",
                                 bus.cap_valid ? K_CAP : K_ERR, bus.cap_idx, bus.cap_num, cyc,
                                 e.kind, e.idx, e.num, e.cyc);
                    end
                end
            end
            if (bus.frame_done) begin
                n_events++;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_frame actual=frame_done cyc=%0d required=none", cyc);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    if (e.kind != K_FRM || e.cyc != cyc) begin
                        failures++;
                        $display("FAIL frame_done actual=kind%0d cyc%0d required=kind%0d cyc%0d",
                                 K_FRM, cyc, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int ev0;
        drive(4'b0000, 7'b0000000);
        step(3);
        rst = 1'b0;
        step(2);
        chk("rst_num", bus.num, 0);
        chk("rst_dv", bus.digit_valid, 0);
        chk("rst_idx", bus.cap_idx, 0);
        chk("rst_capnum", bus.cap_num, 0);

        // Single legal capture: digit 2 shows 5.
        drive(4'b0100, 7'b1011011); push(K_CAP, 2, 5, cyc + LAT);
        step(10);
        drive(4'b0000, 7'b0000000); step(3);
        chk("single_num", bus.num, 32'h0500);
        chk("single_dv", bus.digit_valid, 4'b0100);
        chk("single_idx", bus.cap_idx, 2);

        // Asynchronous reset mid-SETTLE discards the pending capture.
        drive(4'b0001, 7'b1111110);
        step(2);
        #3 rst = 1'b1;
        #1;
        chk("arst_num", bus.num, 0);
        chk("arst_dv", bus.digit_valid, 0);
        chk("arst_idx", bus.cap_idx, 0);
        chk("arst_capnum", bus.cap_num, 0);
        step(1);
        rst = 1'b0;
        push(K_CAP, 0, 0, cyc + LAT);
        step(8);
        drive(4'b0000, 7'b0000000); step(3);

        // Full frame: digits 0..3 show 1,2,3,4.
        drive(4'b0001, 7'b0110000); push(K_CAP, 0, 1, cyc + LAT); step(8);
        drive(4'b0010, 7'b1101101); push(K_CAP, 1, 2, cyc + LAT); step(8);
        drive(4'b0100, 7'b1111001); push(K_CAP, 2, 3, cyc + LAT); step(8);
        drive(4'b1000, 7'b0110011); push(K_CAP, 3, 4, cyc + LAT);
        push(K_FRM, 0, 0, cyc + LAT + 1); step(8);
        drive(4'b0000, 7'b0000000); step(3);
        chk("frame_num", bus.num, 32'h4321);
        chk("frame_dv", bus.digit_valid, 4'hF);

        // Glitch rejection: 3-cycle holds never capture.
        for (int k = 0; k < 4; k++) begin
            drive(4'b0001, (k % 2 == 0) ? 7'b0110000 : 7'b1111111);
            step(3);
        end
        drive(4'b0001, 7'b0110000); push(K_CAP, 0, 1, cyc + LAT); step(10);
        chk("glitch_capnum", bus.cap_num, 1);

        // Digit 1 shows 7, then an illegal pattern with the same strobe.
        drive(4'b0010, 7'b1110000); push(K_CAP, 1, 7, cyc + LAT); step(7);
        drive(4'b0010, 7'b0000001); push(K_ERR, 1, 7, cyc + LAT); step(6);
        drive(4'b0000, 7'b0000000); step(4);
        chk("illegal_dv", bus.digit_valid, 4'b1101);
        chk("illegal_num1", bus.num[7:4], 7);
        chk("illegal_idx", bus.cap_idx, 1);

        // Strobe errors: two bits set, then none.
        ev0 = n_events;
        drive(4'b0011, 7'b1111110); step(20);
        drive(4'b0000, 7'b1111110); step(20);
        chk("strobe_err_events", n_events, ev0);
        chk("strobe_err_dv", bus.digit_valid, 4'b1101);

        // Hold exactly STABLE_CYCLES edges: no capture; STABLE_CYCLES+1: capture.
        drive(4'b0100, 7'b1111111); step(SC);
        drive(4'b0001, 7'b1111001); push(K_CAP, 0, 3, cyc + LAT); step(SC + 1);
        drive(4'b0000, 7'b0000000); step(12);
        chk("boundary_num", bus.num, 32'h4373);
        chk("boundary_dv", bus.digit_valid, 4'b1101);

        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
